// File: rtl/n_term_ram_io_gen.sv
// North-terminal tile for the RAM IO column.
// Every north-travelling wire entering from the south is looped back onto a
// south-travelling wire through a per-output any-to-any mux, with an optional
// one-cycle pipeline flop per output. Mux selections and pipeline enables live
// in on-tile configuration flops loaded through the frame interface. Frame
// strobes, frame data and the user clock pass straight through to the
// neighbouring tile.
module n_term_ram_io_gen #(
  parameter int MaxFramesPerCol = 20,
  parameter int FrameBitsPerRow = 32,
  parameter int W1              = 4,
  parameter int W2              = 8,
  parameter int W4              = 16
) (
  input  logic                       UserCLK,
  input  logic                       UserRSTn,
  output logic                       UserCLKo,
  input  logic [W1-1:0]              N1END,
  input  logic [W2-1:0]              N2MID,
  input  logic [W2-1:0]              N2END,
  input  logic [W4-1:0]              N4END,
  output logic [W1-1:0]              S1BEG,
  output logic [W2-1:0]              S2BEG,
  output logic [W2-1:0]              S2BEGb,
  output logic [W4-1:0]              S4BEG,
  input  logic [FrameBitsPerRow-1:0] FrameData,
  output logic [FrameBitsPerRow-1:0] FrameData_O,
  input  logic [MaxFramesPerCol-1:0] FrameStrobe,
  output logic [MaxFramesPerCol-1:0] FrameStrobe_O
);

  // Number of looped-back wires (inputs and outputs pair up one-to-one).
  localparam int NIN           = W1 + 2*W2 + W4;
  // Selector width: value 0 means tie-low, 1..NIN pick an input.
  localparam int SEL_W         = $clog2(NIN + 1);
  // One field per output: selector plus the pipeline-enable bit on top.
  localparam int FIELD_W       = SEL_W + 1;
  localparam int NoConfigBits  = NIN * FIELD_W;
  localparam int FrameCapacity = MaxFramesPerCol * FrameBitsPerRow;

  // The configuration must fit into the frames available to the column.
  generate
    if (NoConfigBits > FrameCapacity) begin : g_cfg_overflow
      $error("n_term_ram_io_gen: %0d config bits do not fit in %0d frame bits",
             NoConfigBits, FrameCapacity);
    end
  endgenerate

  logic [NoConfigBits-1:0] cfg_q;
  logic [NoConfigBits-1:0] cfg_d;
  logic [NIN-1:0]          pipe_q;
  logic [NIN-1:0]          pipe_d;

  logic [NIN-1:0]          in_vec;
  logic [NIN:0]            in_ext;
  logic [NIN-1:0]          sel_val;
  logic [NIN-1:0]          out_vec;

  // Flat input order, LSB first: N1END, N2MID, N2END, N4END.
  assign in_vec = {N4END, N2END, N2MID, N1END};
  // Position 0 is the tie-low source so a selector indexes this vector directly.
  assign in_ext = {in_vec, 1'b0};

  // Config bit i belongs to frame i / FrameBitsPerRow at row bit
  // i % FrameBitsPerRow. Frame bits past the last config bit have no flop,
  // so writes to them simply vanish.
  generate
    for (genvar gi = 0; gi < NoConfigBits; gi++) begin : g_cfg_bit
      localparam int FRAME_IDX = gi / FrameBitsPerRow;
      localparam int ROW_BIT   = gi % FrameBitsPerRow;
      assign cfg_d[gi] = FrameStrobe[FRAME_IDX] ? FrameData[ROW_BIT] : cfg_q[gi];
    end
  endgenerate

  // Per-output mux and output-mode select.
  generate
    for (genvar gi = 0; gi < NIN; gi++) begin : g_out
      logic [SEL_W-1:0] sel;
      logic             reg_en;

      assign sel    = cfg_q[gi*FIELD_W +: SEL_W];
      assign reg_en = cfg_q[gi*FIELD_W + SEL_W];

      // Selectors beyond the last input read as tie-low rather than wrapping.
      assign sel_val[gi] = (sel <= SEL_W'(NIN)) ? in_ext[sel] : 1'b0;

      // The pipeline flop always tracks the mux, so turning registering on
      // shows the previous cycle's sample at once with no empty cycle.
      assign out_vec[gi] = reg_en ? pipe_q[gi] : sel_val[gi];
    end
  endgenerate

  assign pipe_d = sel_val;

  // Configuration and pipeline flops; reset clears both and wins over frame writes.
  always_ff @(posedge UserCLK) begin
    if (!UserRSTn) begin
      cfg_q  <= '0;
      pipe_q <= '0;
    end else begin
      cfg_q  <= cfg_d;
      pipe_q <= pipe_d;
    end
  end

  // Flat output order mirrors the input order.
  assign {S4BEG, S2BEGb, S2BEG, S1BEG} = out_vec;

  // Pass-throughs to the neighbouring tile, independent of reset.
  assign UserCLKo      = UserCLK;
  assign FrameData_O   = FrameData;
  assign FrameStrobe_O = FrameStrobe;

endmodule

// File: tb/tb_n_term_ram_io_gen.sv
// Testbench for n_term_ram_io_gen: table-driven loop-back vectors, hand-written
// multi-cycle sequences, a randomized run against a behavioural model, and a
// reduced-width instance for the parameter sweep.
module tb_n_term_ram_io_gen;

  localparam int NIN  = 36;
  localparam int FW   = 7;
  localparam int NCFG = NIN * FW;

  logic        UserCLK;
  logic        UserRSTn;
  logic        UserCLKo;
  logic [3:0]  N1END;
  logic [7:0]  N2MID;
  logic [7:0]  N2END;
  logic [15:0] N4END;
  logic [3:0]  S1BEG;
  logic [7:0]  S2BEG;
  logic [7:0]  S2BEGb;
  logic [15:0] S4BEG;
  logic [31:0] FrameData;
  logic [31:0] FrameData_O;
  logic [19:0] FrameStrobe;
  logic [19:0] FrameStrobe_O;

  // Reduced-width instance signals.
  logic        clko2;
  logic [1:0]  n1b2;
  logic [3:0]  n2m2;
  logic [3:0]  n2e2;
  logic [7:0]  n4b2;
  logic [1:0]  s1b2;
  logic [3:0]  s2b2;
  logic [3:0]  s2bb2;
  logic [7:0]  s4b2;
  logic [31:0] fd2;
  logic [31:0] fd2_o;
  logic [19:0] fs2;
  logic [19:0] fs2_o;

  int vectors;
  int miscompares;

  n_term_ram_io_gen dut (
    .UserCLK(UserCLK), .UserRSTn(UserRSTn), .UserCLKo(UserCLKo),
    .N1END(N1END), .N2MID(N2MID), .N2END(N2END), .N4END(N4END),
    .S1BEG(S1BEG), .S2BEG(S2BEG), .S2BEGb(S2BEGb), .S4BEG(S4BEG),
    .FrameData(FrameData), .FrameData_O(FrameData_O),
    .FrameStrobe(FrameStrobe), .FrameStrobe_O(FrameStrobe_O)
  );

  n_term_ram_io_gen #(.W1(2), .W2(4), .W4(8)) dut_small (
    .UserCLK(UserCLK), .UserRSTn(UserRSTn), .UserCLKo(clko2),
    .N1END(n1b2), .N2MID(n2m2), .N2END(n2e2), .N4END(n4b2),
    .S1BEG(s1b2), .S2BEG(s2b2), .S2BEGb(s2bb2), .S4BEG(s4b2),
    .FrameData(fd2), .FrameData_O(fd2_o),
    .FrameStrobe(fs2), .FrameStrobe_O(fs2_o)
  );

  initial UserCLK = 1'b0;
  always #5 UserCLK = ~UserCLK;

  // ---------------- behavioural reference model ----------------
  bit cfg_m  [NCFG];
  bit pipe_m [NIN];

  function automatic logic [35:0] cur_in();
    return {N4END, N2END, N2MID, N1END};
  endfunction

  function automatic logic [35:0] out_act();
    return {S4BEG, S2BEGb, S2BEG, S1BEG};
  endfunction

  function automatic int field_sel(int k);
    int s = 0;
    for (int j = 0; j < FW - 1; j++) s += int'(cfg_m[k*FW + j]) << j;
    return s;
  endfunction

  function automatic bit pick(int k, logic [35:0] iv);
    int s = field_sel(k);
    if (s >= 1 && s <= NIN) return iv[s-1];
    return 1'b0;
  endfunction

  function automatic logic [35:0] model_out();
    logic [35:0] o;
    logic [35:0] iv = cur_in();
    for (int k = 0; k < NIN; k++)
      o[k] = cfg_m[k*FW + FW - 1] ? pipe_m[k] : pick(k, iv);
    return o;
  endfunction

  function automatic logic [255:0] cfg_model_vec();
    logic [255:0] v = '0;
    for (int i = 0; i < NCFG; i++) v[i] = cfg_m[i];
    return v;
  endfunction

  // Apply one clock edge to the model using the inputs the DUT is about to sample.
  task automatic model_edge();
    logic [35:0] iv = cur_in();
    if (!UserRSTn) begin
      for (int i = 0; i < NCFG; i++) cfg_m[i] = 1'b0;
      for (int k = 0; k < NIN; k++) pipe_m[k] = 1'b0;
    end else begin
      for (int k = 0; k < NIN; k++) pipe_m[k] = pick(k, iv);
      for (int f = 0; f < 20; f++)
        if (FrameStrobe[f])
          for (int b = 0; b < 32; b++)
            if (f*32 + b < NCFG) cfg_m[f*32 + b] = FrameData[b];
    end
  endtask

  // ---------------- helpers ----------------
  task automatic cmp(string name, logic [255:0] act, logic [255:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge UserCLK);
    #1;
  endtask

  task automatic set_in(logic [35:0] v);
    {N4END, N2END, N2MID, N1END} = v;
  endtask

  task automatic check_all(string name);
    cmp({name, "_out"}, 256'(out_act()), 256'(model_out()));
    cmp({name, "_fd_o"}, 256'(FrameData_O), 256'(FrameData));
    cmp({name, "_fs_o"}, 256'(FrameStrobe_O), 256'(FrameStrobe));
    cmp({name, "_clko"}, 256'(UserCLKo), 256'(UserCLK));
  endtask

  task automatic write_frames(logic [19:0] strobes, logic [31:0] data);
    FrameStrobe = strobes;
    FrameData   = data;
    tick();
    FrameStrobe = '0;
  endtask

  task automatic do_reset();
    UserRSTn = 1'b0;
    tick();
    UserRSTn = 1'b1;
  endtask

  typedef struct {
    logic [31:0] fd;
    logic [35:0] inv;
    logic [35:0] exp;
  } vec_t;

  vec_t tbl [8];

  initial begin
    bit          pat [4];
    bit          pexp[5];
    logic [255:0] cfg_exp;
    vectors     = 0;
    miscompares = 0;

    // sel0=1 follows N1END[0]; sel0=36 follows N4END[15]; 37 and 0 tie low;
    // several fields at once; field 4 selector low bits from frame 0 top nibble.
    tbl[0] = '{32'h0000_0001, 36'h0_0000_0001, 36'h0_0000_0001};
    tbl[1] = '{32'h0000_0001, 36'h0_0000_0000, 36'h0_0000_0000};
    tbl[2] = '{32'd36,        36'h8_0000_0000, 36'h0_0000_0001};
    tbl[3] = '{32'd36,        36'h7_FFFF_FFFF, 36'h0_0000_0000};
    tbl[4] = '{32'd37,        36'hF_FFFF_FFFF, 36'h0_0000_0000};
    tbl[5] = '{32'h0000_0000, 36'hF_FFFF_FFFF, 36'h0_0000_0000};
    tbl[6] = '{32'h00A1_0182, 36'h0_0000_001A, 36'h0_0000_000D};
    tbl[7] = '{32'h9000_0000, 36'h0_0000_0100, 36'h0_0000_0010};

    // Reset with all inputs high and frame activity present.
    UserRSTn    = 1'b0;
    set_in('1);
    FrameStrobe = 20'h00005;
    FrameData   = 32'hDEADBEEF;
    fs2 = '0; fd2 = '0; n1b2 = '0; n2m2 = '0; n2e2 = '0; n4b2 = '0;
    #1;
    cmp("rst_fs_o_early", 256'(FrameStrobe_O), 256'(20'h00005));
    cmp("rst_fd_o_early", 256'(FrameData_O), 256'(32'hDEADBEEF));
    tick();
    tick();
    cmp("rst_out", 256'(out_act()), 256'(0));
    cmp("rst_cfg", 256'(dut.cfg_q), 256'(0));
    cmp("rst_pipe", 256'(dut.pipe_q), 256'(0));
    cmp("rst_fs_o", 256'(FrameStrobe_O), 256'(20'h00005));
    cmp("rst_fd_o", 256'(FrameData_O), 256'(32'hDEADBEEF));
    check_all("rst");
    UserRSTn    = 1'b1;
    FrameStrobe = '0;
    FrameData   = '0;
    set_in('0);

    // Table-driven combinational loop-back.
    for (int i = 0; i < 8; i++) begin
      write_frames(20'h00001, tbl[i].fd);
      set_in(tbl[i].inv);
      #1;
      cmp($sformatf("tbl%0d", i), 256'(out_act()), 256'(tbl[i].exp));
      check_all($sformatf("tbl%0d", i));
    end

    // Registered mode: field 4 = {reg=1, sel=5} spans frames 0 and 1.
    do_reset();
    set_in('0);
    write_frames(20'h00001, 32'h5000_0000);
    write_frames(20'h00002, 32'h0000_0004);
    pat  = '{1'b1, 1'b0, 1'b1, 1'b1};
    pexp = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 5; i++) begin
      N2MID[0] = (i < 4) ? pat[i] : 1'b0;
      #1;
      cmp($sformatf("regpipe%0d", i), 256'(S2BEG[0]), 256'(pexp[i]));
      check_all("regpipe");
      tick();
    end

    // Frame boundary: frames 7 and 1 together; bits past 251 vanish.
    do_reset();
    write_frames(20'h00082, 32'hFFFF_FFFF);
    cfg_exp = '0;
    cfg_exp[63:32]   = '1;
    cfg_exp[251:224] = '1;
    cmp("frame_bound_cfg", 256'(dut.cfg_q), cfg_exp);
    check_all("frame_bound");

    // Reset beats a simultaneous frame write.
    UserRSTn    = 1'b0;
    FrameStrobe = 20'h00001;
    FrameData   = 32'hFFFF_FFFF;
    tick();
    cmp("rst_vs_write", 256'(dut.cfg_q), 256'(0));
    UserRSTn    = 1'b1;
    FrameStrobe = '0;

    // Reset in the middle of a registered stream.
    set_in('0);
    write_frames(20'h00001, 32'h0000_0041);
    N1END[0] = 1'b1;
    tick();
    cmp("stream_pre", 256'(S1BEG[0]), 256'(1));
    UserRSTn = 1'b0;
    tick();
    cmp("stream_rst", 256'(S1BEG[0]), 256'(0));
    UserRSTn = 1'b1;
    tick();
    tick();
    cmp("stream_post", 256'(S1BEG[0]), 256'(0));
    check_all("stream");

    // Randomized run against the model.
    for (int c = 0; c < 400; c++) begin
      UserRSTn = ($urandom_range(0, 99) < 3) ? 1'b0 : 1'b1;
      case ($urandom_range(0, 5))
        0:       FrameStrobe = 20'(1) << $urandom_range(0, 8);
        1:       FrameStrobe = (20'(1) << $urandom_range(0, 7)) | (20'(1) << $urandom_range(0, 7));
        default: FrameStrobe = '0;
      endcase
      FrameData = $urandom;
      set_in({4'($urandom), 32'($urandom)});
      #1;
      check_all("rand_pre");
      tick();
      cmp("rand_cfg", 256'(dut.cfg_q), cfg_model_vec());
      check_all("rand_post");
    end
    UserRSTn    = 1'b1;
    FrameStrobe = '0;

    // Reduced widths: sel=18 reaches N4END[7] on outputs 0 and 3.
    fs2 = 20'h00001;
    fd2 = 32'h0048_0012;
    tick();
    fs2 = '0;
    {n4b2, n2e2, n2m2, n1b2} = 18'h20000;
    #1;
    cmp("sweep_hi", 256'({s2b2[1], s1b2[0]}), 256'(2'b11));
    {n4b2, n2e2, n2m2, n1b2} = 18'h1FFFF;
    #1;
    cmp("sweep_lo", 256'({s2b2[1], s1b2[0]}), 256'(2'b00));
    cmp("sweep_rest", 256'({s4b2, s2bb2, s2b2[3:2], s2b2[0], s1b2[1]}), 256'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
